morse_emit_char: RTL and testbench
==================================

// Module: morse_emit_char
// PURPOSE
//  Morse character transmitter; mirror of the capture path. Accepts one coded character
//  (len + dit/dah bit vector) per valid/ready handshake. Drives keyed `signal` high/low
//  with dit/dah/gap durations counted in ce ticks, then the inter-char or inter-word gap.
//  Sits between the text-to-Morse encoder and the key/tone output; its `signal` must
//  decode back losslessly through the capture block given the same timing inputs.
// PARAMETERS
//  DEBUG  0  1 = $display trace of accepted chars and state changes (simulation only)
//  Widths come from defines.vh: `PULSE_CNT_W, `MORSE_LEN_W, `MAX_MORSE_LEN
// PORTS
//  clk        in   1                clock; all logic on posedge
//  aclr_n     in   1                synchronous reset, active-low
//  ce         in   1                tick enable; all state/counters advance only when ce=1
//  dit_time   in   `PULSE_CNT_W     dit mark and intra-char space length, ticks
//  dah_time   in   `PULSE_CNT_W     dah mark and inter-char gap length, ticks
//  word_time  in   `PULSE_CNT_W     inter-word gap length, ticks
//  valid      in   1                len/dits_dahs/word_end_in hold a char to send
//  len        in   `MORSE_LEN_W     element count, 1..`MAX_MORSE_LEN
//  dits_dahs  in   `MAX_MORSE_LEN   1=dah 0=dit; first element at bit len-1, last at bit 0
//  word_end_in in  1                trailing gap is word_time instead of dah_time
//  ready      out  1                1 only in IDLE; transfer = ce & valid & ready
//  signal     out  1                keyed output, 1 = mark
//  busy       out  1                ~ready
//  error      out  1                see CONFIGURATION
//  ceo        out  1                one-ce-tick pulse (ce & done) when trailing gap ends
// BEHAVIOUR
//  - Reset (aclr_n=0 on a clk edge, regardless of ce): state=IDLE, signal=0, ready=1,
//    error=0, ceo=0, counters/latches=0. Reset mid-character aborts it; signal low next cycle.
//  - On transfer: latch len, dits_dahs, word_end_in, times; state MARK, element idx=len-1.
//    signal rises at the same edge (0 ticks latency). Inputs ignored until back in IDLE.
//  - FSM (transitions on ce edges only; counter loads T-1, decrements to 0):
//    IDLE -> MARK on transfer.
//    MARK: signal=1 for dit_time (bit=0) or dah_time (bit=1) ticks; then idx==0 -> TAIL,
//      else -> SPACE.
//    SPACE: signal=0 for dit_time ticks; idx-=1; -> MARK.
//    TAIL: signal=0 for word_time if word_end_in else dah_time ticks; last tick raises
//      ceo (combinational ce & done flag) and returns to IDLE, ready=1 next edge.
//  - Timing values latched at transfer; later changes affect next char only.
//  - Any time value of 0 is treated as 1 tick. Counter width `PULSE_CNT_W, no wrap.
//  - ce=0: all outputs hold, ceo=0.
//  - Back-to-back: valid held high with new data is accepted on the first ce tick in IDLE;
//    no extra gap beyond TAIL.
// CONFIGURATION
//  MORSE_EMIT_LEN_CHECK_EN defined: transfer with len==0 or len>`MAX_MORSE_LEN sets
//    error=1 (sticky until next good transfer or reset), sends only TAIL gap, pulses ceo.
//  Not defined: error tied 0; len==0 sends only TAIL; len>`MAX_MORSE_LEN clamped to max.
// TESTING (dit=2, dah=6, word=14, ce=1 unless stated)
//  1 'A': len=2, dits_dahs=..01, word_end_in=0 -> signal 1x2,0x2,1x6,0x6; ceo on tick 16;
//    ready=1 tick 17.
//  2 'E' word end: len=1, bits=0, word_end_in=1 -> signal 1x2, 0x14, one ceo pulse.
//  3 ce every 3rd clk, 'T' (len=1,bit=1) -> mark lasts 18 clks, ceo only on a ce cycle.
//  4 reset low at tick 4 of 'O' (len=3,bits=111) -> signal=0, ready=1 next edge, no ceo.
//  5 loopback into capture block, chars A,B,SOS-style len=`MAX_MORSE_LEN -> identical
//    len/dits_dahs out, error=0, word_end after word_end_in char.
//  6 MORSE_EMIT_LEN_CHECK_EN, len=0 -> error=1, signal stays 0 for 6 ticks, ceo once;
//    next good char clears error.

Source files
------------

// File: rtl/morse_emit_char.sv
// Morse character transmitter: keys one coded character per valid/ready handshake, then the
// inter-char or inter-word gap. Optional length checking via `MORSE_EMIT_LEN_CHECK_EN.
`ifndef PULSE_CNT_W
`define PULSE_CNT_W 16
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 4
`endif
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 8
`endif

module morse_emit_char (
  input  logic                      clk,
  input  logic                      aclr_n,
  input  logic                      ce,
  input  logic [`PULSE_CNT_W-1:0]   dit_time,
  input  logic [`PULSE_CNT_W-1:0]   dah_time,
  input  logic [`PULSE_CNT_W-1:0]   word_time,
  input  logic                      valid,
  input  logic [`MORSE_LEN_W-1:0]   len,
  input  logic [`MAX_MORSE_LEN-1:0] dits_dahs,
  input  logic                      word_end_in,
  output logic                      ready,
  output logic                      signal,
  output logic                      busy,
  output logic                      error,
  output logic                      ceo
);
  localparam int unsigned CntW = `PULSE_CNT_W;
  localparam int unsigned IdxW = (`MAX_MORSE_LEN > 1) ? $clog2(`MAX_MORSE_LEN) : 1;
  localparam logic [`MORSE_LEN_W-1:0] MaxLen = `MORSE_LEN_W'(`MAX_MORSE_LEN);

  typedef enum logic [1:0] {StIdle, StMark, StSpace, StTail} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [CntW-1:0]           dit_q, dit_d, dah_q, dah_d, word_q, word_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [`MAX_MORSE_LEN-1:0] bits_q, bits_d;
  logic                      word_end_q, word_end_d;
  logic                      err_q, err_d;

  logic                      transfer, done, len_err, tail_only;
  logic [`MORSE_LEN_W-1:0]   len_eff;

  // Counter preload for a duration of t ticks; a zero duration behaves as one tick.
  function automatic logic [CntW-1:0] load(input logic [CntW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  assign transfer = ce & valid & (state_q == StIdle);
  assign done     = (state_q == StTail) && (cnt_q == '0);

`ifdef MORSE_EMIT_LEN_CHECK_EN
  assign len_err  = (len == '0) || (len > MaxLen);
`else
  assign len_err  = 1'b0;
`endif
  assign tail_only = (len == '0) || len_err;
  assign len_eff   = (len > MaxLen) ? MaxLen : len;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dit_d      = dit_q;
    dah_d      = dah_q;
    word_d     = word_q;
    idx_d      = idx_q;
    bits_d     = bits_q;
    word_end_d = word_end_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          dit_d      = dit_time;
          dah_d      = dah_time;
          word_d     = word_time;
          bits_d     = dits_dahs;
          word_end_d = word_end_in;
          err_d      = len_err;
          if (tail_only) begin
            state_d = StTail;
            cnt_d   = load(word_end_in ? word_time : dah_time);
          end else begin
            state_d = StMark;
            idx_d   = IdxW'(len_eff - 1'b1);
            cnt_d   = load(dits_dahs[idx_d] ? dah_time : dit_time);
          end
        end
      end
      StMark: begin
        if (ce) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (idx_q == '0) begin
            state_d = StTail;
            cnt_d   = load(word_end_q ? word_q : dah_q);
          end else begin
            state_d = StSpace;
            cnt_d   = load(dit_q);
          end
        end
      end
      StSpace: begin
        if (ce) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = StMark;
            idx_d   = idx_q - 1'b1;
            cnt_d   = load(bits_q[idx_d] ? dah_q : dit_q);
          end
        end
      end
      StTail: begin
        if (ce) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dit_q      <= '0;
      dah_q      <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      bits_q     <= '0;
      word_end_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dit_q      <= dit_d;
      dah_q      <= dah_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      bits_q     <= bits_d;
      word_end_q <= word_end_d;
      err_q      <= err_d;
    end
  end

  assign ready  = (state_q == StIdle);
  assign busy   = ~ready;
  assign signal = (state_q == StMark);
  assign error  = err_q;
  assign ceo    = ce & done;

endmodule

// File: tb/tb_morse_emit_char.sv
// Bench for morse_emit_char: hand-computed character table, reset abort, and random chars
// checked cycle by cycle against a duration-list model of the keyed waveform.
`ifndef PULSE_CNT_W
`define PULSE_CNT_W 16
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 4
`endif
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 8
`endif

module tb_morse_emit_char;
  localparam int PW = `PULSE_CNT_W;
  localparam int LW = `MORSE_LEN_W;
  localparam int ML = `MAX_MORSE_LEN;

  logic          clk, aclr_n, ce, valid, word_end_in;
  logic [PW-1:0] dit_time, dah_time, word_time;
  logic [LW-1:0] len;
  logic [ML-1:0] dits_dahs;
  logic          ready, signal, busy, error, ceo;

  morse_emit_char dut (
    .clk        (clk),
    .aclr_n     (aclr_n),
    .ce         (ce),
    .dit_time   (dit_time),
    .dah_time   (dah_time),
    .word_time  (word_time),
    .valid      (valid),
    .len        (len),
    .dits_dahs  (dits_dahs),
    .word_end_in(word_end_in),
    .ready      (ready),
    .signal     (signal),
    .busy       (busy),
    .error      (error),
    .ceo        (ceo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] len;
    logic [ML-1:0] bits;
    logic          we;
    logic [PW-1:0] dit, dah, word;
    int            ce_per;
    int            exp_marks;  // ce ticks with signal=1, -1 = not tabulated
    int            exp_total;  // ce ticks from transfer to ceo, -1 = not tabulated
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  logic exp_q[$];
  logic exp_err;
  logic cur_err;

  function automatic vec_t mk(int l, int b, int we, int d, int h, int w, int per, int m, int t);
    vec_t v;
    v.len = LW'(l); v.bits = ML'(b); v.we = we[0];
    v.dit = PW'(d); v.dah = PW'(h); v.word = PW'(w);
    v.ce_per = per; v.exp_marks = m; v.exp_total = t;
    return v;
  endfunction

  function automatic int eff(input logic [PW-1:0] t);
    return (t == '0) ? 1 : int'(t);
  endfunction

  // Expected waveform: one entry per ce tick after transfer, built from element durations.
  task automatic build(input vec_t v);
    int  n;
    logic bad;
    n = int'(v.len);
`ifdef MORSE_EMIT_LEN_CHECK_EN
    bad = (n == 0) || (n > ML);
`else
    bad = (n == 0);
    if (n > ML) n = ML;
`endif
    exp_err = 1'b0;
`ifdef MORSE_EMIT_LEN_CHECK_EN
    exp_err = bad;
`endif
    exp_q.delete();
    if (!bad) begin
      for (int i = n - 1; i >= 0; i--) begin
        repeat (eff(v.bits[i] ? v.dah : v.dit)) exp_q.push_back(1'b1);
        if (i > 0) repeat (eff(v.dit)) exp_q.push_back(1'b0);
      end
    end
    repeat (eff(v.we ? v.word : v.dah)) exp_q.push_back(1'b0);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic send(input vec_t v, input int abort_at);
    int   j, k, marks, ceo_at;
    logic exp_ceo;
    build(v);
    @(negedge clk);
    ce = 1'b1; valid = 1'b1; len = v.len; dits_dahs = v.bits; word_end_in = v.we;
    dit_time = v.dit; dah_time = v.dah; word_time = v.word;
    #1;
    chk1("ready_idle", ready, 1'b1);
    chk1("signal_idle", signal, 1'b0);
    chk1("error_idle", error, cur_err);
    cur_err = exp_err;
    j = 0; k = 0; marks = 0; ceo_at = -1;
    while (j < exp_q.size()) begin
      @(negedge clk);
      if (j == abort_at) begin
        aclr_n = 1'b0; ce = 1'b0; valid = 1'b0;
        @(negedge clk);
        aclr_n = 1'b1; ce = 1'b1;
        #1;
        chk1("abort_signal", signal, 1'b0);
        chk1("abort_ready", ready, 1'b1);
        chk1("abort_ceo", ceo, 1'b0);
        chk1("abort_error", error, 1'b0);
        cur_err = 1'b0;
        return;
      end
      ce = ((k % v.ce_per) == v.ce_per - 1);
      // Scramble inputs while busy: they must be ignored and times must stay latched.
      valid = 1'($urandom); len = LW'($urandom); dits_dahs = ML'($urandom);
      word_end_in = 1'($urandom);
      dit_time = PW'($urandom_range(0, 9)); dah_time = PW'($urandom_range(0, 9));
      word_time = PW'($urandom_range(0, 9));
      #1;
      exp_ceo = ce && (j == exp_q.size() - 1);
      chk1("signal", signal, exp_q[j]);
      chk1("ceo", ceo, exp_ceo);
      chk1("ready_busy", ready, 1'b0);
      chk1("busy", busy, 1'b1);
      chk1("error", error, cur_err);
      if (ce && signal) marks++;
      if (ceo) ceo_at = j + 1;
      if (ce) j++;
      k++;
    end
    if (v.exp_total >= 0) begin
      chki("tbl_marks", marks, v.exp_marks);
      chki("tbl_total", ceo_at, v.exp_total);
    end
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(2, 'b01, 0, 2, 6, 14, 1, 8, 16);           // 'A'
    tbl[1] = mk(1, 'b0, 1, 2, 6, 14, 1, 2, 16);            // 'E' word end
    tbl[2] = mk(1, 'b1, 0, 2, 6, 14, 3, 6, 12);            // 'T', ce every 3rd clk
    tbl[3] = mk(0, 0, 0, 2, 6, 14, 1, 0, 6);               // len 0: tail only
    tbl[4] = mk(ML, 'hE3, 1, 2, 6, 14, 1, 36, 64);         // full length, word end
    tbl[5] = mk(2, 'b10, 0, 0, 0, 0, 1, 2, 4);             // zero times act as 1
`ifdef MORSE_EMIT_LEN_CHECK_EN
    tbl[6] = mk(ML + 4, 'h0F, 0, 3, 5, 7, 1, 0, 5);        // over-length rejected
`else
    tbl[6] = mk(ML + 4, 'h0F, 0, 3, 5, 7, 1, 32, 58);      // over-length clamped
`endif
    tbl[7] = mk(4, 'b1000, 1, 1, 3, 7, 2, 6, 16);          // 'B', ce every 2nd clk

    aclr_n = 1'b0; ce = 1'b0; valid = 1'b0; len = '0; dits_dahs = '0; word_end_in = 1'b0;
    dit_time = '0; dah_time = '0; word_time = '0;
    cur_err = 1'b0;
    repeat (3) @(negedge clk);
    ce = 1'b1;
    #1;
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_signal", signal, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk1("rst_ceo", ceo, 1'b0);
    aclr_n = 1'b1;

    for (int i = 0; i < 8; i++) send(tbl[i], -1);

    // Reset four ticks into 'O', then a clean 'A' afterwards.
    send(mk(3, 'b111, 0, 2, 6, 14, 1, -1, -1), 4);
    send(tbl[0], -1);

    for (int i = 0; i < 30; i++) begin
      rv = mk($urandom_range(0, ML + 2), int'($urandom), int'($urandom_range(0, 1)),
              $urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 9),
              $urandom_range(1, 3), -1, -1);
      send(rv, -1);
    end

    @(negedge clk);
    valid = 1'b0; ce = 1'b1;
    #1;
    chk1("final_ready", ready, 1'b1);
    chk1("final_error", error, cur_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
